// File: rtl/calc_operand_sequencer_pkg.sv
// calc_operand_sequencer_pkg: FSM state encoding and default operand width shared with display/LED logic
package calc_operand_sequencer_pkg;
  localparam int CALC_WIDTH = 4;
  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    FIRE   = 2'b10,
    SHOW   = 2'b11
  } calc_state_t;
endpackage

// File: rtl/calc_operand_sequencer_btn_debounce.sv
// btn_debounce: synchronizes a raw button, accepts a level after DEBOUNCE_CYCLES stable samples, pulses on press
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic meta, s, stable, stable_q;
  logic [CW-1:0] cnt;
  // two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {meta, s} <= 2'b00;
    else {meta, s} <= {raw, meta};
  // accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      stable <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      stable_q <= stable;
      if (s == stable) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  assign level = stable;
  assign press = stable & ~stable_q;
endmodule

// File: rtl/calc_operand_sequencer.sv
// calc_operand_sequencer: captures operands A then B/Cin on debounced presses and pulses enable once per calculation
module calc_operand_sequencer
  import calc_operand_sequencer_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             sw_cin,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Cin,
  output logic             enable,
  output logic [1:0]       state
);
  calc_state_t cur, nxt;
  logic [WIDTH-1:0] a_n, b_n;
  logic cin_n, load_p, clear_p, load_level, clear_level, unused_levels;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk(clk), .reset_n(reset_n), .raw(btn_load), .level(load_level), .press(load_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .reset_n(reset_n), .raw(btn_clear), .level(clear_level), .press(clear_p)
  );
  assign unused_levels = load_level ^ clear_level;
  // state and operand registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cur <= LOAD_A;
      A <= '0;
      B <= '0;
      Cin <= 1'b0;
    end else begin
      cur <= nxt;
      A <= a_n;
      B <= b_n;
      Cin <= cin_n;
    end
  // next state and captures; clear wins over load, a load during FIRE is dropped
  always_comb begin
    nxt = cur;
    a_n = A;
    b_n = B;
    cin_n = Cin;
    enable = 1'b0;
    if (clear_p) begin
      nxt = LOAD_A;
      a_n = '0;
      b_n = '0;
      cin_n = 1'b0;
    end else
      case (cur)
        LOAD_A: if (load_p) begin a_n = sw; nxt = LOAD_B; end
        LOAD_B: if (load_p) begin b_n = sw; cin_n = sw_cin; nxt = FIRE; end
        FIRE: begin enable = 1'b1; nxt = SHOW; end
        SHOW: if (load_p) begin a_n = sw; nxt = LOAD_B; end
        default: nxt = LOAD_A;
      endcase
  end
  assign state = cur;
endmodule

// File: tb/tb_calc_operand_sequencer.sv
// tb_calc_operand_sequencer: directed and random button stimulus checked against a history-based reference model
module tb_calc_operand_sequencer;
  localparam int DC = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [3:0] sw = '0;
  logic sw_cin = 1'b0, btn_load = 1'b0, btn_clear = 1'b0;
  logic [3:0] A, B;
  logic Cin, enable;
  logic [1:0] state;
  int total = 0, bad = 0, en_cnt = 0;
  logic [1:0] m_state;
  logic [3:0] m_a, m_b;
  logic m_cin, pend_load, pend_clear, sl, sc;
  logic [1:0] dly_l, dly_c;
  logic [DC-1:0] hl, hc;
  int vl, vc;

  calc_operand_sequencer #(.WIDTH(4), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .sw(sw), .sw_cin(sw_cin), .btn_load(btn_load),
    .btn_clear(btn_clear), .A(A), .B(B), .Cin(Cin), .enable(enable), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 2'd0; m_a = '0; m_b = '0; m_cin = 1'b0;
    pend_load = 1'b0; pend_clear = 1'b0; sl = 1'b0; sc = 1'b0;
    dly_l = '0; dly_c = '0; hl = '0; hc = '0; vl = 0; vc = 0;
  endtask

  // a level is accepted once the last DC synchronized samples all disagree with it
  task automatic deb(input logic raw, inout logic [1:0] dly, inout logic [DC-1:0] h,
                     inout int v, inout logic stab, output logic rose);
    logic s;
    s = dly[1];
    h = {h[DC-2:0], s};
    v++;
    rose = 1'b0;
    if (v >= DC && h == {DC{~stab}}) begin
      stab = ~stab;
      rose = stab;
    end
    dly = {dly[0], raw};
  endtask

  task automatic model_step();
    logic rl, rc;
    if (pend_clear) begin
      m_state = 2'd0; m_a = '0; m_b = '0; m_cin = 1'b0;
    end else if (m_state == 2'd0 || m_state == 2'd3) begin
      if (pend_load) begin m_a = sw; m_state = 2'd1; end
    end else if (m_state == 2'd1) begin
      if (pend_load) begin m_b = sw; m_cin = sw_cin; m_state = 2'd2; end
    end else m_state = 2'd3;
    deb(btn_load, dly_l, hl, vl, sl, rl);
    deb(btn_clear, dly_c, hc, vc, sc, rc);
    pend_load = rl;
    pend_clear = rc;
  endtask

  task automatic compare();
    chk("outs", 32'({state, enable, Cin, B, A}),
        32'({m_state, (m_state == 2'd2) && !pend_clear, m_cin, m_b, m_a}));
    if (enable) en_cnt++;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      if (reset_n) model_step(); else model_reset();
      @(negedge clk);
      compare();
    end
  endtask

  task automatic push(input int hi, input int lo);
    btn_load = 1'b1;
    cyc(hi);
    btn_load = 1'b0;
    cyc(lo);
  endtask

  initial begin
    model_reset();
    cyc(3);
    reset_n = 1'b1;
    cyc(20);
    chk("idle", 32'({A, B, Cin, enable, state}), 0);
    en_cnt = 0;
    sw = 4'h9;
    push(10, 10);
    chk("calc_a", 32'(A), 9);
    chk("calc_st_b", 32'(state), 1);
    sw = 4'h7; sw_cin = 1'b1;
    push(10, 10);
    chk("calc_b", 32'(B), 7);
    chk("calc_cin", 32'(Cin), 1);
    chk("calc_show", 32'(state), 3);
    chk("calc_en_cnt", en_cnt, 1);
    sw = 4'h5;
    push(10, 10);
    chk("chain_a", 32'(A), 5);
    en_cnt = 0;
    btn_load = 1'b1; btn_clear = 1'b1;
    cyc(10);
    btn_load = 1'b0; btn_clear = 1'b0;
    cyc(10);
    chk("clr_state", 32'(state), 0);
    chk("clr_ops", 32'({A, B, Cin}), 0);
    chk("clr_en_cnt", en_cnt, 0);
    sw = 4'hC;
    for (int i = 0; i < 2; i++) begin
      btn_load = 1'b1; cyc(2);
      btn_load = 1'b0; cyc(2);
    end
    btn_load = 1'b1;
    cyc(6);
    chk("bounce_wait", 32'(state), 0);
    cyc(1);
    chk("bounce_take", 32'(state), 1);
    cyc(1);
    btn_load = 1'b0;
    cyc(10);
    chk("bounce_a", 32'(A), 12);
    chk("bounce_once", 32'(state), 1);
    sw = 4'hF;
    btn_load = 1'b1; cyc(3);
    btn_load = 1'b0; cyc(10);
    chk("glitch_state", 32'(state), 1);
    chk("glitch_b", 32'(B), 0);
    sw = 4'h2; sw_cin = 1'b0;
    push(10, 10);
    chk("run2_b", 32'(B), 2);
    sw = 4'h3;
    push(10, 10);
    chk("show_chain", 32'({A, B, state}), 32'({4'h3, 4'h2, 2'b01}));
    btn_load = 1'b1;
    cyc(4);
    @(posedge clk);
    model_step();
    #2 reset_n = 1'b0;
    model_reset();
    #1 chk("rst_press", 32'({A, B, Cin, enable, state}), 0);
    @(negedge clk);
    compare();
    reset_n = 1'b1; btn_load = 1'b0;
    cyc(10);
    sw = 4'hA;
    push(10, 10);
    sw = 4'h6; btn_load = 1'b1;
    for (int i = 0; i < 20 && m_state != 2'd2; i++) cyc(1);
    chk("fire_reached", 32'(enable), 1);
    reset_n = 1'b0;
    model_reset();
    #1 chk("rst_fire", 32'({A, B, Cin, enable, state}), 0);
    cyc(2);
    reset_n = 1'b1; btn_load = 1'b0;
    cyc(10);
    for (int i = 0; i < 200; i++) begin
      btn_load = 1'($urandom_range(0, 1));
      btn_clear = ($urandom_range(0, 9) == 0);
      sw = 4'($urandom);
      sw_cin = 1'($urandom);
      cyc($urandom_range(1, 12));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
